switch_allocator: RTL and testbench
===================================

# switch_allocator

Wormhole switch allocator for the 5-port mesh router. Each cycle it arbitrates the buffered input flits competing for each output port. It holds an output for one packet from head flit to tail flit and tracks downstream credits per output. Its grants pop the input buffers, and its per-output select drives the crossbar switch.

## Interface
Parameters:
- NUM_PORTS, 5, router ports; index 0 N, 1 E, 2 S, 3 W, 4 PE
- BUF_DEPTH, 4, downstream buffer slots per output (initial credits)
- CNT_W, $clog2(BUF_DEPTH+1), credit counter width

Ports:
- clk  in  1  single router clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  input i has a flit at its buffer head
- req_head  in  NUM_PORTS  that flit is a head flit
- req_tail  in  NUM_PORTS  that flit is a tail flit; head+tail means a single-flit packet
- req_port  in  3*NUM_PORTS  output requested by input i, from route computation
- credit_in  in  NUM_PORTS  one-cycle pulse meaning downstream of output o freed one slot
- grant  out  NUM_PORTS  input i's flit traverses the crossbar this cycle; the buffer pops it
- xbar_sel  out  3*NUM_PORTS  input index routed to output o
- xbar_valid  out  NUM_PORTS  output o carries a valid flit this cycle

## Operation
- Each output o has state IDLE or LOCKED(owner), a round-robin pointer rr_ptr[o] and a credit count cnt[o].
- Eligibility:
  - A request from input i targets output o when req_valid[i] is set and req_port[i]==o.
  - A req_port value of NUM_PORTS or more is ignored.
  - No output is granted while cnt[o]==0.
- IDLE output:
  - Only head-flit requests compete; body or tail requests to an IDLE output are ignored.
  - The winner is the first requester at or after rr_ptr[o], wrapping at NUM_PORTS.
  - On a win, rr_ptr[o] becomes winner+1 mod NUM_PORTS.
  - If the winning flit is not a tail, the output goes to LOCKED(winner). A head+tail winner leaves it IDLE.
- LOCKED(owner) output:
  - Only the owner's request is considered; all others are blocked.
  - The owner is granted when its request targets o and a credit is available.
  - A granted tail returns the output to IDLE. rr_ptr is unchanged while locked.
- Each input requests exactly one output, so grant[i] is the OR over outputs of "o granted i". At most one grant per input.
- Credits:
  - cnt[o]_next = cnt[o] - xbar_valid[o] + credit_in[o].
  - A simultaneous grant and credit leaves the count unchanged.
  - credit_in while cnt==BUF_DEPTH and no grant saturates; the count never exceeds BUF_DEPTH.
- When xbar_valid[o]==0, xbar_sel[o] is 0.

## Timing
- grant, xbar_sel and xbar_valid are combinational from the current requests and registered state. Request to grant takes 0 cycles, so the flit crosses in the same cycle.
- Lock, rr_ptr and cnt updates become visible at the next edge. A credit_in in cycle t enables a grant in cycle t+1 at the earliest.
- Reset values:
  - All outputs IDLE, rr_ptr=0, cnt=BUF_DEPTH.
  - grant, xbar_valid and xbar_sel are forced to 0 while rst is high.
- Reset asserted mid-packet drops every lock immediately. Inputs must re-present head flits after reset.
- Sustained throughput is one flit per output per cycle while credits last.

## Structure
- Shared package noc_pkg holds:
  - NUM_PORTS and the PORT_N/E/S/W/PE index constants
  - the 3-bit port-index type
  - the flit-type encoding (head/body/tail) used by the buffers and route computation
- Sub-module rr_arbiter (NUM_PORTS-wide request vector plus pointer in, one-hot grant and winner index out), instantiated once per output.
- Lock state, pointers and credit counters live in switch_allocator.

## Test plan
- After reset, inputs 0 and 2 both send head+tail flits to output 4 each cycle -> grants alternate 0,2,0,2; xbar_sel[4] follows; rr_ptr[4] advances each grant.
- Input 1 sends a 3-flit packet to E while input 3 sends a head to E -> input 3 is blocked for three cycles; E unlocks after the tail and input 3 wins the next cycle.
- BUF_DEPTH=4, no credit_in, input 0 streams to N -> four grants, then stalls; one credit_in pulse -> exactly one more grant, in the following cycle.
- Credit stress: cnt=4, grant and credit_in in the same cycle -> cnt stays 4; credit_in with no grant -> cnt stays 4 (saturated).
- Body flit to an IDLE output, or req_port=6 -> no grant and no state change.
- rst pulsed while output S is LOCKED -> outputs 0 during reset; afterwards S is IDLE and any new head can win.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices, port-index type, flit encoding,
// allocator output state and a wrapping pointer increment.
package noc_pkg;

   localparam int NUM_PORTS = 5;

   localparam int PORT_N  = 0;
   localparam int PORT_E  = 1;
   localparam int PORT_S  = 2;
   localparam int PORT_W  = 3;
   localparam int PORT_PE = 4;

   typedef logic [2:0] port_idx_t;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic {
      OUT_IDLE   = 1'b0,
      OUT_LOCKED = 1'b1
   } out_state_e;

   function automatic port_idx_t wrap_inc(port_idx_t p, int n);
      if (int'(p) >= n - 1) return '0;
      return p + 3'd1;
   endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the allocator and the crossbar.
// slave is the allocator side; master drives requests and credits.
interface switch_allocator_if #(
   parameter int NP = noc_pkg::NUM_PORTS
) ();

   logic [NP-1:0]   req_valid;
   logic [NP-1:0]   req_head;
   logic [NP-1:0]   req_tail;
   logic [3*NP-1:0] req_port;
   logic [NP-1:0]   credit_in;
   logic [NP-1:0]   grant;
   logic [3*NP-1:0] xbar_sel;
   logic [NP-1:0]   xbar_valid;

   modport slave (
      input  req_valid, req_head, req_tail, req_port, credit_in,
      output grant, xbar_sel, xbar_valid
   );

   modport master (
      output req_valid, req_head, req_tail, req_port, credit_in,
      input  grant, xbar_sel, xbar_valid
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i, wrapping at N.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int N = NUM_PORTS
) (
   input  logic [N-1:0] req_i,
   input  port_idx_t    ptr_i,
   output logic [N-1:0] gnt_o,
   output port_idx_t    idx_o,
   output logic         vld_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             sel;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      sel   = 0;
      // Rotate so bit 0 is the pointer position; the lowest set bit then wins.
      dbl   = {req_i, req_i} >> ptr_i;
      rot   = dbl[N-1:0];
      for (int k = 0; k < N; k++) begin
         if (!vld_o && rot[k]) begin
            vld_o = 1'b1;
            sel   = int'(ptr_i) + k;
            if (sel >= N) sel = sel - N;
            idx_o = port_idx_t'(sel);
         end
      end
      if (vld_o) gnt_o = {{(N-1){1'b0}}, 1'b1} << idx_o;
   end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output lock from head to tail, round-robin among
// competing heads, downstream credit tracking. Grants are combinational.
module switch_allocator #(
   parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   switch_allocator_if.slave sa_if
);

   import noc_pkg::*;

   out_state_e       state_q  [NUM_PORTS];
   out_state_e       state_d  [NUM_PORTS];
   port_idx_t        owner_q  [NUM_PORTS];
   port_idx_t        owner_d  [NUM_PORTS];
   port_idx_t        rr_ptr_q [NUM_PORTS];
   port_idx_t        rr_ptr_d [NUM_PORTS];
   logic [CNT_W-1:0] cnt_q    [NUM_PORTS];
   logic [CNT_W-1:0] cnt_d    [NUM_PORTS];

   logic [NUM_PORTS-1:0] tgt     [NUM_PORTS];
   logic [NUM_PORTS-1:0] arb_req [NUM_PORTS];
   logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
   port_idx_t            arb_idx [NUM_PORTS];
   logic                 arb_vld [NUM_PORTS];
   logic [NUM_PORTS-1:0] gnt_oh  [NUM_PORTS];
   port_idx_t            out_sel [NUM_PORTS];
   logic [NUM_PORTS-1:0] out_vld;
   logic [NUM_PORTS-1:0] out_tail;
   logic [NUM_PORTS-1:0] has_credit;
   logic [NUM_PORTS-1:0] gnt_in;
   logic [3*NUM_PORTS-1:0] sel_flat;

   // Out-of-range req_port values never match an output index, so they drop out here.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         tgt[o]        = '0;
         has_credit[o] = (cnt_q[o] != '0);
         for (int i = 0; i < NUM_PORTS; i++) begin
            tgt[o][i] = sa_if.req_valid[i] && (sa_if.req_port[3*i +: 3] == port_idx_t'(o));
         end
         arb_req[o] = (state_q[o] == OUT_IDLE && has_credit[o]) ? (tgt[o] & sa_if.req_head) : '0;
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter #(.N(NUM_PORTS)) u_arb (
         .req_i (arb_req[o]),
         .ptr_i (rr_ptr_q[o]),
         .gnt_o (arb_gnt[o]),
         .idx_o (arb_idx[o]),
         .vld_o (arb_vld[o])
      );
   end

   always_comb begin
      gnt_in   = '0;
      out_vld  = '0;
      out_tail = '0;
      sel_flat = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt_oh[o]  = '0;
         out_sel[o] = '0;
         if (state_q[o] == OUT_LOCKED) begin
            if (has_credit[o] && tgt[o][owner_q[o]]) begin
               out_vld[o]             = 1'b1;
               out_sel[o]             = owner_q[o];
               gnt_oh[o][owner_q[o]]  = 1'b1;
            end
         end else if (arb_vld[o]) begin
            out_vld[o] = 1'b1;
            out_sel[o] = arb_idx[o];
            gnt_oh[o]  = arb_gnt[o];
         end
         out_tail[o] = out_vld[o] && sa_if.req_tail[out_sel[o]];
         gnt_in      = gnt_in | gnt_oh[o];
         sel_flat[3*o +: 3] = out_sel[o];
      end
      if (rst) begin
         gnt_in   = '0;
         out_vld  = '0;
         out_tail = '0;
         sel_flat = '0;
      end
   end

   assign sa_if.grant      = gnt_in;
   assign sa_if.xbar_valid = out_vld;
   assign sa_if.xbar_sel   = sel_flat;

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         state_d[o]  = state_q[o];
         owner_d[o]  = owner_q[o];
         rr_ptr_d[o] = rr_ptr_q[o];
         cnt_d[o]    = cnt_q[o];
         if (out_vld[o]) begin
            if (state_q[o] == OUT_IDLE) begin
               rr_ptr_d[o] = wrap_inc(arb_idx[o], NUM_PORTS);
               if (!out_tail[o]) begin
                  state_d[o] = OUT_LOCKED;
                  owner_d[o] = arb_idx[o];
               end
            end else if (out_tail[o]) begin
               state_d[o] = OUT_IDLE;
            end
         end
         // Grant and credit together cancel; a credit at full count is absorbed.
         if (out_vld[o] && !sa_if.credit_in[o]) begin
            cnt_d[o] = cnt_q[o] - CNT_W'(1);
         end else if (!out_vld[o] && sa_if.credit_in[o] && cnt_q[o] != CNT_W'(BUF_DEPTH)) begin
            cnt_d[o] = cnt_q[o] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o]  <= OUT_IDLE;
            owner_q[o]  <= '0;
            rr_ptr_q[o] <= '0;
            cnt_q[o]    <= CNT_W'(BUF_DEPTH);
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o]  <= state_d[o];
            owner_q[o]  <= owner_d[o];
            rr_ptr_q[o] <= rr_ptr_d[o];
            cnt_q[o]    <= cnt_d[o];
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: round-robin, wormhole lock, credits,
// ignored requests and mid-packet reset, with hand-computed expected outputs.
module tb_switch_allocator;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   switch_allocator_if #(.NP(5)) sif ();

   switch_allocator #(.NUM_PORTS(5), .BUF_DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .sa_if (sif)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] sel(input int o, input int i);
      logic [14:0] v;
      v = 15'(i);
      return v << (3 * o);
   endfunction

   task automatic clr();
      sif.req_valid = '0;
      sif.req_head  = '0;
      sif.req_tail  = '0;
      sif.req_port  = '0;
      sif.credit_in = '0;
   endtask

   task automatic req(input int i, input int port, input logic h, input logic t);
      sif.req_valid[i]        = 1'b1;
      sif.req_head[i]         = h;
      sif.req_tail[i]         = t;
      sif.req_port[3*i +: 3]  = 3'(port);
   endtask

   // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
   task automatic step(input string tag, input logic [4:0] eg, input logic [4:0] ev, input logic [14:0] es);
      @(negedge clk);
      check_eq({tag, ".grant"}, 32'(sif.grant), 32'(eg));
      check_eq({tag, ".xvld"},  32'(sif.xbar_valid), 32'(ev));
      check_eq({tag, ".xsel"},  32'(sif.xbar_sel), 32'(es));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clr();
      req(0, 4, 1'b1, 1'b1);
      step("reset", 5'b00000, 5'b00000, 15'd0);
      rst = 1'b0;
      clr();

      // Two single-flit requesters on PE, credits returned every cycle.
      req(0, 4, 1'b1, 1'b1);
      req(2, 4, 1'b1, 1'b1);
      sif.credit_in = 5'b10000;
      step("rr0", 5'b00001, 5'b10000, sel(4, 0));
      step("rr1", 5'b00100, 5'b10000, sel(4, 2));
      step("rr2", 5'b00001, 5'b10000, sel(4, 0));
      step("rr3", 5'b00100, 5'b10000, sel(4, 2));
      clr();
      sif.credit_in = 5'b10000;
      step("sat", 5'b00000, 5'b00000, 15'd0);
      clr();
      req(0, 4, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) step($sformatf("pe_drain%0d", k), 5'b00001, 5'b10000, 15'd0);
      step("pe_stall", 5'b00000, 5'b00000, 15'd0);
      clr();

      // Credit exhaustion on N, then a single returned credit.
      req(0, 0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) step($sformatf("n_drain%0d", k), 5'b00001, 5'b00001, 15'd0);
      step("n_stall", 5'b00000, 5'b00000, 15'd0);
      sif.credit_in = 5'b00001;
      step("n_credit", 5'b00000, 5'b00000, 15'd0);
      sif.credit_in = 5'b00000;
      step("n_regrant", 5'b00001, 5'b00001, 15'd0);
      step("n_stall2", 5'b00000, 5'b00000, 15'd0);
      clr();

      // Three-flit packet from input 1 holds E against input 3.
      req(1, 1, 1'b1, 1'b0);
      req(3, 1, 1'b1, 1'b0);
      step("e_head", 5'b00010, 5'b00010, sel(1, 1));
      req(1, 1, 1'b0, 1'b0);
      step("e_body", 5'b00010, 5'b00010, sel(1, 1));
      req(1, 1, 1'b0, 1'b1);
      step("e_tail", 5'b00010, 5'b00010, sel(1, 1));
      sif.req_valid[1] = 1'b0;
      step("e_next", 5'b01000, 5'b00010, sel(1, 3));
      clr();

      // Ignored requests, then a head from input 4 wins S and wraps the pointer.
      req(4, 2, 1'b0, 1'b0);
      step("s_body_idle", 5'b00000, 5'b00000, 15'd0);
      req(4, 6, 1'b1, 1'b1);
      step("bad_port", 5'b00000, 5'b00000, 15'd0);
      req(4, 2, 1'b1, 1'b1);
      step("s_single", 5'b10000, 5'b00100, sel(2, 4));
      clr();

      // Lock S to input 2, then reset mid-packet.
      req(2, 2, 1'b1, 1'b0);
      step("s_lock", 5'b00100, 5'b00100, sel(2, 2));
      req(2, 2, 1'b0, 1'b0);
      req(0, 2, 1'b1, 1'b0);
      step("s_locked", 5'b00100, 5'b00100, sel(2, 2));
      rst = 1'b1;
      step("s_in_rst", 5'b00000, 5'b00000, 15'd0);
      rst = 1'b0;
      step("s_after_rst", 5'b00001, 5'b00100, sel(2, 0));
      clr();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
